// File: rtl/tdm_pkg.sv
// tdm_pkg -- shared types for the test-done monitor.
//   tdm_state_e   : monitor state encoding (IDLE, WARMUP, RUN, PASS, FAIL, TIMEOUT)
//   tdm_verdict_t : one-hot verdict bundle {timeout, fail, pass}
//   verdict_of()  : maps a state to its verdict bundle
//   idx_w()       : width of a channel index, never below 1 bit
package tdm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_RUN     = 3'd2,
    ST_PASS    = 3'd3,
    ST_FAIL    = 3'd4,
    ST_TIMEOUT = 3'd5
  } tdm_state_e;

  typedef struct packed {
    logic timeout;
    logic fail;
    logic pass;
  } tdm_verdict_t;

  function automatic tdm_verdict_t verdict_of(input tdm_state_e st);
    tdm_verdict_t v;
    v = '{timeout: 1'b0, fail: 1'b0, pass: 1'b0};
    case (st)
      ST_PASS:    v.pass    = 1'b1;
      ST_FAIL:    v.fail    = 1'b1;
      ST_TIMEOUT: v.timeout = 1'b1;
      default:    v = '{timeout: 1'b0, fail: 1'b0, pass: 1'b0};
    endcase
    return v;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_prio_enc.sv
// tdm_prio_enc -- lowest-set-bit priority encoder.
//   req   : N-bit request vector
//   idx   : index of the lowest set bit (0 when none set)
//   valid : high when any request bit is set
module tdm_prio_enc
  import tdm_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  output logic [idx_w(N)-1:0] idx,
  output logic                valid
);

  localparam int IW = idx_w(N);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      idx   = req[i] ? IW'(i) : idx;
      valid = valid | req[i];
    end
  end

endmodule

// File: rtl/test_done_monitor.sv
// test_done_monitor -- watches NUM_CH sub-test channels and issues a verdict.
//   After start the monitor warms up for WARMUP_CYC cycles, then declares
//   FAIL on any recorded error, PASS once every channel has finished, or
//   TIMEOUT after TIMEOUT_CYC cycles (only when TDM_TIMEOUT_EN is defined;
//   otherwise the run waits indefinitely and timeout stays 0).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : one-cycle pulse, honoured in IDLE or a terminal state
//   finish[NUM_CH], err[NUM_CH] : per-channel status, level or pulse
//   busy, done            : run in progress / verdict available
//   pass, fail, timeout   : one-hot verdict
//   fin_seen, err_seen    : sticky per-channel flags
//   first_err             : lowest index among the first error report
//   cycles                : cycles since start, saturating, frozen at verdict
module test_done_monitor
  import tdm_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int WARMUP_CYC  = 1000,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CNT_W       = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        finish,
  input  logic [NUM_CH-1:0]        err,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout,
  output logic [NUM_CH-1:0]        fin_seen,
  output logic [NUM_CH-1:0]        err_seen,
  output logic [idx_w(NUM_CH)-1:0] first_err,
  output logic [CNT_W-1:0]         cycles
);

  localparam int FE_W = idx_w(NUM_CH);
  // WARMUP_CYC of 0 or 1 both leave WARMUP on the first cycle after start.
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARMUP_CYC > 0) ? WARMUP_CYC - 1 : 0);

  tdm_state_e          state_r, state_nxt_s, verdict_nxt_s;
  tdm_verdict_t        verdict_nxt_bits_s;
  logic                busy_r, done_r, pass_r, fail_r, timeout_r;
  logic [NUM_CH-1:0]   fin_seen_r, err_seen_r;
  logic [NUM_CH-1:0]   fin_nxt_s, err_nxt_s;
  logic [FE_W-1:0]     first_err_r;
  logic [CNT_W-1:0]    cycles_r;
  logic [FE_W-1:0]     enc_idx_s;
  logic                enc_valid_s;
  logic                active_s, launch_s, warm_done_s, to_hit_s;

  tdm_prio_enc #(.N(NUM_CH)) u_prio_enc (
    .req   (err),
    .idx   (enc_idx_s),
    .valid (enc_valid_s)
  );

  assign active_s    = (state_r == ST_WARMUP) || (state_r == ST_RUN);
  assign launch_s    = start && !active_s;
  assign warm_done_s = (cycles_r >= WARM_LAST);
  // Flags as they will be after this edge; verdicts look at these so the
  // decision lands on the cycle after the triggering input.
  assign fin_nxt_s   = fin_seen_r | finish;
  assign err_nxt_s   = err_seen_r | err;

`ifdef TDM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  assign to_hit_s = (cycles_r >= TO_LAST);
`else
  // Timeout disabled: constant 0, parameter kept referenced.
  assign to_hit_s = 1'b0 & (TIMEOUT_CYC != 0);
`endif

  // Verdict evaluation for a RUN cycle (also the WARMUP exit): FAIL > PASS > TIMEOUT.
  always_comb begin
    verdict_nxt_s = ST_RUN;
    if (|err_nxt_s) begin
      verdict_nxt_s = ST_FAIL;
    end else if (&fin_nxt_s) begin
      verdict_nxt_s = ST_PASS;
    end else if (to_hit_s) begin
      verdict_nxt_s = ST_TIMEOUT;
    end else begin
      verdict_nxt_s = ST_RUN;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_PASS, ST_FAIL, ST_TIMEOUT: begin
        if (start) state_nxt_s = ST_WARMUP;
        else       state_nxt_s = state_r;
      end
      ST_WARMUP: begin
        if (warm_done_s) state_nxt_s = verdict_nxt_s;
        else             state_nxt_s = ST_WARMUP;
      end
      ST_RUN:  state_nxt_s = verdict_nxt_s;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  assign verdict_nxt_bits_s = verdict_of(state_nxt_s);

  // State register and registered status outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      fail_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      busy_r    <= (state_nxt_s == ST_WARMUP) || (state_nxt_s == ST_RUN);
      done_r    <= (state_nxt_s == ST_PASS) || (state_nxt_s == ST_FAIL) ||
                   (state_nxt_s == ST_TIMEOUT);
      pass_r    <= verdict_nxt_bits_s.pass;
      fail_r    <= verdict_nxt_bits_s.fail;
      timeout_r <= verdict_nxt_bits_s.timeout;
    end
  end

  // Sticky flags, first-error index and cycle counter; cleared by a honoured start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_seen_r  <= '0;
      err_seen_r  <= '0;
      first_err_r <= '0;
      cycles_r    <= '0;
    end else if (launch_s) begin
      fin_seen_r  <= '0;
      err_seen_r  <= '0;
      first_err_r <= '0;
      cycles_r    <= '0;
    end else if (active_s) begin
      fin_seen_r <= fin_nxt_s;
      err_seen_r <= err_nxt_s;
      if (!(|err_seen_r) && enc_valid_s) first_err_r <= enc_idx_s;
      else                               first_err_r <= first_err_r;
      if (cycles_r != {CNT_W{1'b1}}) cycles_r <= cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
      else                           cycles_r <= cycles_r;
    end else begin
      fin_seen_r  <= fin_seen_r;
      err_seen_r  <= err_seen_r;
      first_err_r <= first_err_r;
      cycles_r    <= cycles_r;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign fail      = fail_r;
  assign timeout   = timeout_r;
  assign fin_seen  = fin_seen_r;
  assign err_seen  = err_seen_r;
  assign first_err = first_err_r;
  assign cycles    = cycles_r;

endmodule

// File: tb/tb_test_done_monitor.sv
// Testbench for test_done_monitor (NUM_CH=4, WARMUP_CYC=10, TIMEOUT_CYC=50).
// Stimulus pushes the predicted verdict into a queue; a monitor process pops
// and compares whenever done rises.
module tb_test_done_monitor;

  localparam int NCH = 4;
  localparam int W   = 10;
  localparam int TO  = 50;
  localparam int L   = 64;
`ifdef TDM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic        p, f, t;
    logic [31:0] cyc;
    logic [3:0]  fs, es;
    logic [1:0]  fe;
  } exp_t;

  logic        clk, rst_n, start;
  logic [3:0]  finish, err;
  logic        busy, done, pass, fail, timeout;
  logic [3:0]  fin_seen, err_seen;
  logic [1:0]  first_err;
  logic [31:0] cycles;

  logic [3:0]  fin_a[L];
  logic [3:0]  err_a[L];
  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  test_done_monitor #(.NUM_CH(NCH), .WARMUP_CYC(W), .TIMEOUT_CYC(TO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .err(err),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .fin_seen(fin_seen), .err_seen(err_seen), .first_err(first_err), .cycles(cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference: the verdict is decided at the earliest evaluation point
  // (first RUN-eligible cycle at or after the trigger), ties FAIL > PASS > TIMEOUT.
  function automatic bit predict(output exp_t e);
    int t_err, t_fin, ef, ep, et, endk, big, w1;
    logic [3:0] acc;
    big = 1000000; w1 = (W > 0) ? W - 1 : 0;
    t_err = -1; t_fin = -1; acc = 4'd0;
    for (int k = 0; k < L; k++) begin
      acc = acc | fin_a[k];
      if (acc == 4'hF && t_fin < 0) t_fin = k;
      if (err_a[k] != 4'd0 && t_err < 0) t_err = k;
    end
    ef = (t_err < 0) ? big : imax(t_err, w1);
    ep = (t_fin < 0) ? big : imax(t_fin, w1);
    et = TO_EN ? imax(TO - 1, w1) : big;
    e = '{p: 1'b0, f: 1'b0, t: 1'b0, cyc: 32'd0, fs: 4'd0, es: 4'd0, fe: 2'd0};
    if (ef <= ep && ef <= et && ef < big) begin e.f = 1'b1; endk = ef; end
    else if (ep <= et && ep < big)        begin e.p = 1'b1; endk = ep; end
    else if (et < big)                    begin e.t = 1'b1; endk = et; end
    else return 1'b0;
    if (endk >= L) return 1'b0;
    e.cyc = 32'(endk + 1);
    for (int k = 0; k <= endk; k++) begin
      e.fs = e.fs | fin_a[k];
      e.es = e.es | err_a[k];
    end
    if (e.f) begin
      for (int b = 3; b >= 0; b--) if (err_a[t_err][b]) e.fe = 2'(b);
    end
    return 1'b1;
  endfunction

  task automatic clear_vec();
    for (int k = 0; k < L; k++) begin fin_a[k] = 4'd0; err_a[k] = 4'd0; end
  endtask

  // Drives one run: start pulse, then per-cycle vectors; optional start while
  // busy at cycle 2 and optional reset at cycle rst_at.
  task automatic drive_run(input int ncyc, input bit mid_start, input int rst_at);
    exp_t e;
    if (predict(e) && rst_at < 0) q.push_back(e);
    @(negedge clk); start = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      start  = mid_start && (k == 2);
      finish = (k < L) ? fin_a[k] : 4'd0;
      err    = (k < L) ? err_a[k] : 4'd0;
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("reset_clears", {busy, done, pass, fail, timeout, fin_seen, err_seen, first_err, cycles}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        break;
      end
    end
    @(negedge clk); start = 1'b0; finish = 4'd0; err = 4'd0;
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    check("verdict_pending", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  // Monitor: compare against the scoreboard whenever done rises.
  initial begin
    logic done_q;
    exp_t e;
    done_q = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (done && !done_q) begin
        if (q.size() == 0) begin
          check("unexpected_verdict", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("pass", 64'(pass), 64'(e.p));
          check("fail", 64'(fail), 64'(e.f));
          check("timeout", 64'(timeout), 64'(e.t));
          check("cycles", 64'(cycles), 64'(e.cyc));
          check("fin_seen", 64'(fin_seen), 64'(e.fs));
          check("err_seen", 64'(err_seen), 64'(e.es));
          if (e.f) check("first_err", 64'(first_err), 64'(e.fe));
        end
      end
      done_q = done;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; finish = 4'd0; err = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", {busy, done, pass, fail, timeout, fin_seen, err_seen, first_err, cycles}, 64'd0);

    // Staggered finishes -> PASS at cycle 21.
    clear_vec();
    fin_a[3] = 4'b0001; fin_a[12] = 4'b0010; fin_a[15] = 4'b0100; fin_a[20] = 4'b1000;
    drive_run(L, 1'b1, -1);

    // Two-bit error in RUN -> FAIL at 15, first_err 1.
    clear_vec();
    err_a[14] = 4'b0110;
    drive_run(L, 1'b0, -1);

    // Error during warmup -> FAIL on the first RUN cycle.
    clear_vec();
    err_a[4] = 4'b0100;
    drive_run(L, 1'b0, -1);

    // Completion and error on the same cycle -> FAIL wins.
    clear_vec();
    fin_a[12] = 4'b0111; fin_a[16] = 4'b1000; err_a[16] = 4'b0001;
    drive_run(L, 1'b0, -1);

    // Incomplete finish: TIMEOUT at 50 when enabled, otherwise still busy.
    clear_vec();
    fin_a[5] = 4'b0111;
    drive_run(200, 1'b0, -1);
    check("busy_at_200", 64'(busy), 64'(!TO_EN));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-RUN at cycle 30, then a clean run.
    clear_vec();
    fin_a[5] = 4'b0011;
    drive_run(L, 1'b0, 30);

    for (int r = 0; r < 20; r++) begin
      bit use_err;
      clear_vec();
      use_err = 1'($urandom_range(0, 1));
      for (int k = 0; k < L; k++) begin
        if ($urandom_range(0, 7) == 0) fin_a[k] = 4'($urandom_range(0, 15));
        if (use_err && $urandom_range(0, 39) == 0) err_a[k] = 4'($urandom_range(1, 15));
      end
      fin_a[$urandom_range(0, 40)] = 4'hF;
      drive_run(L, 1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
